// File: rtl/keypad_pkg.sv
// Shared key codes, debounce FSM state encoding and key classification helper
// for the keypad entry buffer.
package keypad_pkg;

   localparam logic [4:0] KEY_NONE  = 5'b11111;
   localparam logic [4:0] KEY_BKSP  = 5'b11100;
   localparam logic [4:0] KEY_ENTER = 5'b11110;
   localparam logic [4:0] KEY_CLEAR = 5'b11000;
   localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_ACT,
      ST_HOLD,
      ST_RELEASE
   } kp_state_e;

   typedef enum logic [1:0] {
      KC_NONE,
      KC_DIGIT,
      KC_SPECIAL
   } key_class_e;

   function automatic key_class_e classify_key(input logic [4:0] code);
      key_class_e cls;
      if (code <= KEY_DIGIT_MAX) begin
         cls = KC_DIGIT;
      end else if (code == KEY_BKSP || code == KEY_ENTER || code == KEY_CLEAR) begin
         cls = KC_SPECIAL;
      end else begin
         cls = KC_NONE;
      end
      return cls;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounce/press tracker: turns a stable key code into one accept pulse per
// press, then waits for a stable release before arming again.
module key_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 1000,
   parameter int unsigned CNT_W         = 10
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [4:0] key_i,
   output logic       accept_o,
   output logic [4:0] code_o
);

   localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   kp_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic [4:0]       cand_q;
   logic [4:0]       key_n;
   logic             accept_q;

   // Unlisted codes behave exactly like an idle keypad.
   always_comb begin
      key_n = key_i;
      if (classify_key(key_i) == KC_NONE) begin
         key_n = KEY_NONE;
      end
   end

   assign cnt_inc = cnt_q + CNT_ONE;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         cand_q   <= KEY_NONE;
         accept_q <= 1'b0;
      end else begin
         accept_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (key_n != KEY_NONE) begin
                  cand_q  <= key_n;
                  cnt_q   <= CNT_ONE;
                  state_q <= ST_DEBOUNCE;
               end
            end
            ST_DEBOUNCE: begin
               if (key_n != cand_q) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == STABLE_LIM) begin
                     state_q  <= ST_ACT;
                     accept_q <= 1'b1;
                  end
               end
            end
            ST_ACT: begin
               cnt_q   <= '0;
               state_q <= ST_HOLD;
            end
            ST_HOLD: begin
               if (key_n == KEY_NONE) begin
                  cnt_q   <= CNT_ONE;
                  state_q <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               // Any key activity restarts the release window without re-arming.
               if (key_n != KEY_NONE) begin
                  cnt_q <= '0;
               end else if (cnt_inc == STABLE_LIM) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign accept_o = accept_q;
   assign code_o   = cand_q;

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: debounced presses drive an NDIGITS-deep BCD buffer.
// Define KEYPAD_AUTO_CLEAR_EN to clear the buffer on an accepted enter.
module keypad_entry_buffer
   import keypad_pkg::*;
#(
   parameter int unsigned NDIGITS       = 4,
   parameter int unsigned STABLE_CYCLES = 1000,
   parameter int unsigned CNT_W         = 10
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [4:0]             Key,
   output logic [4*NDIGITS-1:0]   Digits,
   output logic [2:0]             DigitCount,
   output logic                   KeyStrobe,
   output logic                   EntryValid,
   output logic [4*NDIGITS-1:0]   EntryValue,
   output logic                   Overflow
);

   localparam int unsigned DW   = 4 * NDIGITS;
   localparam logic [2:0]  FULL = 3'(NDIGITS);

   logic          accept;
   logic [4:0]    code;

   logic [DW-1:0] digits_q, digits_d;
   logic [DW-1:0] value_q,  value_d;
   logic [2:0]    count_q,  count_d;
   logic          strobe_q, strobe_d;
   logic          valid_q,  valid_d;
   logic          ovf_q,    ovf_d;

   key_debounce #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_debounce (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .key_i    (Key),
      .accept_o (accept),
      .code_o   (code)
   );

   always_comb begin
      digits_d = digits_q;
      value_d  = value_q;
      count_d  = count_q;
      strobe_d = 1'b0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      if (accept) begin
         strobe_d = 1'b1;
         if (classify_key(code) == KC_DIGIT) begin
            if (count_q < FULL) begin
               digits_d = {digits_q[DW-5:0], code[3:0]};
               count_d  = count_q + 3'd1;
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            case (code)
               KEY_BKSP: begin
                  if (count_q != 3'd0) begin
                     digits_d = {4'h0, digits_q[DW-1:4]};
                     count_d  = count_q - 3'd1;
                  end
               end
               KEY_CLEAR: begin
                  digits_d = '0;
                  count_d  = '0;
               end
               KEY_ENTER: begin
                  if (count_q != 3'd0) begin
                     value_d = digits_q;
                     valid_d = 1'b1;
`ifdef KEYPAD_AUTO_CLEAR_EN
                     digits_d = '0;
                     count_d  = '0;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         digits_q <= '0;
         value_q  <= '0;
         count_q  <= '0;
         strobe_q <= 1'b0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         digits_q <= digits_d;
         value_q  <= value_d;
         count_q  <= count_d;
         strobe_q <= strobe_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   assign Digits     = digits_q;
   assign DigitCount = count_q;
   assign KeyStrobe  = strobe_q;
   assign EntryValid = valid_q;
   assign EntryValue = value_q;
   assign Overflow   = ovf_q;

endmodule
